// File: rtl/atm_bank_resp_pkg.sv
// Shared types for the ATM bank responder and the ATM-side sequencer.
// Holds the request opcodes, response status codes and responder FSM states.
package atm_bank_resp_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_PIN_CHECK   = 2'd0,
    OP_WITHDRAW    = 2'd1,
    OP_BALANCE     = 2'd2,
    OP_END_SESSION = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_BAD_PIN = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_NO_AUTH = 3'd3,
    ST_INSUFF  = 3'd4,
    ST_BAD_AMT = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/atm_pin_guard.sv
// PIN guard: compares the PIN, counts consecutive wrong entries and holds the
// lock flag. Only reset clears the lock.
module atm_pin_guard
  import atm_bank_resp_pkg::*;
#(
  parameter logic [DATA_W-1:0] PIN_VALUE = 16'h1234,
  parameter int unsigned       MAX_TRIES = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              commit_i,
  input  logic [DATA_W-1:0] pin_i,
  output logic              locked_o,
  output logic              pin_match_o,
  output logic              lock_now_o
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  logic [TW-1:0] tries_q, tries_d;
  logic          locked_q, locked_d;
  logic [TW:0]   triesInc;

  assign triesInc    = {1'b0, tries_q} + (TW+1)'(1);
  assign pin_match_o = (pin_i == PIN_VALUE);
  assign lock_now_o  = !locked_q && !pin_match_o && (triesInc == (TW+1)'(MAX_TRIES));
  assign locked_o    = locked_q;

  always_comb begin
    tries_d  = tries_q;
    locked_d = locked_q;
    if (commit_i && !locked_q) begin
      if (pin_match_o) begin
        tries_d = '0;
      end else begin
        tries_d = triesInc[TW-1:0];
        if (lock_now_o) locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tries_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      tries_q  <= tries_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/atm_bank_resp.sv
// Bank-side responder for ATM requests: accepts one request at a time, waits a
// fixed processing delay, then holds a response until the ATM takes it.
module atm_bank_resp
  import atm_bank_resp_pkg::*;
#(
  parameter logic [DATA_W-1:0] PIN_VALUE    = 16'h1234,
  parameter logic [DATA_W-1:0] INIT_BALANCE = 16'd10000,
  parameter int unsigned       PROC_CYCLES  = 4,
  parameter int unsigned       MAX_TRIES    = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              card_removed_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [2:0]        rsp_status_o,
  output logic [DATA_W-1:0] rsp_balance_o
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] balance_q, balance_d;
  logic              auth_q, auth_d;
  status_e           rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0] rsp_balance_q, rsp_balance_d;
  logic              req_ready_q;
  logic              rsp_valid_q;

  logic accept, busyDone, commit;
  logic locked, pinMatch, lockNow;

  assign accept   = req_valid_i && req_ready_q && !card_removed_i;
  assign busyDone = (state_q == S_BUSY) && (cnt_q == CNT_W'(PROC_CYCLES));
  assign commit   = busyDone && !card_removed_i;

  atm_pin_guard #(
    .PIN_VALUE (PIN_VALUE),
    .MAX_TRIES (MAX_TRIES)
  ) u_pin_guard (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .commit_i    (commit && (op_q == OP_PIN_CHECK)),
    .pin_i       (data_q),
    .locked_o    (locked),
    .pin_match_o (pinMatch),
    .lock_now_o  (lockNow)
  );

  // Outcome of the captured request, committed on the edge that enters RESP.
  always_comb begin
    rsp_status_d = ST_OK;
    balance_d    = balance_q;
    auth_d       = auth_q;
    case (op_q)
      OP_PIN_CHECK: begin
        if (locked) begin
          rsp_status_d = ST_LOCKED;
        end else if (pinMatch) begin
          auth_d = 1'b1;
        end else if (lockNow) begin
          rsp_status_d = ST_LOCKED;
          auth_d       = 1'b0;
        end else begin
          rsp_status_d = ST_BAD_PIN;
        end
      end
      OP_WITHDRAW: begin
        if (locked)                   rsp_status_d = ST_LOCKED;
        else if (!auth_q)             rsp_status_d = ST_NO_AUTH;
        else if (data_q == '0)        rsp_status_d = ST_BAD_AMT;
        else if (data_q > balance_q)  rsp_status_d = ST_INSUFF;
        else                          balance_d    = balance_q - data_q;
      end
      OP_BALANCE: begin
        if (locked)       rsp_status_d = ST_LOCKED;
        else if (!auth_q) rsp_status_d = ST_NO_AUTH;
      end
      OP_END_SESSION: auth_d = 1'b0;
      default: ;
    endcase
    rsp_balance_d = auth_d ? balance_d : '0;
  end

  // Card removal drops authentication everywhere and aborts any open transaction.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= OP_PIN_CHECK;
      data_q        <= '0;
      balance_q     <= INIT_BALANCE;
      auth_q        <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_balance_q <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
    end else begin
      if (card_removed_i) auth_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q        <= op_e'(req_op_i);
            data_q      <= req_data_i;
            cnt_q       <= '0;
            state_q     <= S_BUSY;
            req_ready_q <= 1'b0;
          end
        end
        S_BUSY: begin
          if (card_removed_i) begin
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end else if (busyDone) begin
            cnt_q         <= '0;
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_status_q  <= rsp_status_d;
            rsp_balance_q <= rsp_balance_d;
            balance_q     <= balance_d;
            auth_q        <= auth_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (card_removed_i || rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_status_o  = rsp_status_q;
  assign rsp_balance_o = rsp_balance_q;

endmodule

// File: tb/tb_atm_bank_resp.sv
// Scoreboard bench for atm_bank_resp: directed requests push expected responses,
// a negedge monitor compares every presented response against the queue head.
module tb_atm_bank_resp;
  import atm_bank_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cardRemoved;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [15:0] reqData;
  logic        rspValid;
  logic        rspReady;
  logic [2:0]  rspStatus;
  logic [15:0] rspBalance;

  typedef struct {
    logic [2:0]  status;
    logic [15:0] balance;
    int          acceptCycle;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cycleCnt = 0;
  bit   monEnable = 1'b0;
  bit   latencySeen = 1'b0;

  atm_bank_resp dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .card_removed_i (cardRemoved),
    .req_valid_i    (reqValid),
    .req_ready_o    (reqReady),
    .req_op_i       (reqOp),
    .req_data_i     (reqData),
    .rsp_valid_o    (rspValid),
    .rsp_ready_i    (rspReady),
    .rsp_status_o   (rspStatus),
    .rsp_balance_o  (rspBalance)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Monitor: compares whatever the DUT presents, pops on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (monEnable && rspValid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp: status %0d balance %0d presented, none expected",
                   rspStatus, rspBalance);
        end else begin
          if (!latencySeen) begin
            checkOutput({expQ[0].name, "_latency"}, cycleCnt - expQ[0].acceptCycle, 5);
            latencySeen = 1'b1;
          end
          checkOutput({expQ[0].name, "_status"}, rspStatus, expQ[0].status);
          checkOutput({expQ[0].name, "_balance"}, rspBalance, expQ[0].balance);
          checkOutput({expQ[0].name, "_req_ready"}, reqReady, 0);
          if (rspReady) begin
            void'(expQ.pop_front());
            latencySeen = 1'b0;
          end
        end
      end
    end
  end

  task automatic resetDut();
    monEnable   = 1'b0;
    reset       = 1'b1;
    reqValid    = 1'b0;
    cardRemoved = 1'b0;
    rspReady    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", reqReady, 1);
    checkOutput("reset_rsp_valid", rspValid, 0);
    checkOutput("reset_rsp_status", rspStatus, 0);
    checkOutput("reset_rsp_balance", rspBalance, 0);
    reset = 1'b0;
    expQ.delete();
    latencySeen = 1'b0;
    monEnable   = 1'b1;
  endtask

  task automatic waitReady(input string name, output bit ok);
    int t = 0;
    @(negedge clk);
    while (!reqReady && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = reqReady;
    if (!ok) timeoutFail({name, "_req_ready"});
  endtask

  // Presents one request for a single edge; returns the accept cycle.
  task automatic issueRaw(input logic [1:0] op, input logic [15:0] data,
                          input string name, output int acceptCycle, output bit ok);
    waitReady(name, ok);
    acceptCycle = 0;
    if (ok) begin
      reqOp    = op;
      reqData  = data;
      reqValid = 1'b1;
      @(posedge clk);
      #1;
      reqValid    = 1'b0;
      acceptCycle = cycleCnt;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] data,
                               input status_e expStatus, input logic [15:0] expBal,
                               input string name, input int holdCycles);
    exp_t e;
    int   acc;
    int   t;
    bit   ok;
    rspReady = (holdCycles == 0);
    issueRaw(op, data, name, acc, ok);
    if (!ok) return;
    e.status      = expStatus;
    e.balance     = expBal;
    e.acceptCycle = acc;
    e.name        = name;
    expQ.push_back(e);
    if (holdCycles > 0) begin
      t = 0;
      while (!rspValid && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      repeat (holdCycles) @(posedge clk);
      #1;
      rspReady = 1'b1;
    end
    t = 0;
    while (expQ.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (expQ.size() != 0) begin
      timeoutFail({name, "_response"});
      expQ.delete();
      latencySeen = 1'b0;
    end
  endtask

  initial begin
    int acc;
    bit ok;
    reset       = 1'b1;
    cardRemoved = 1'b0;
    reqValid    = 1'b0;
    reqOp       = 2'd0;
    reqData     = 16'd0;
    rspReady    = 1'b1;

    resetDut();
    applyStimulus(OP_PIN_CHECK, 16'h1234, ST_OK, 16'd10000, "pin_ok", 0);
    applyStimulus(OP_WITHDRAW, 16'd2500, ST_OK, 16'd7500, "wd_2500", 0);
    applyStimulus(OP_WITHDRAW, 16'd7500, ST_OK, 16'd0, "wd_all", 0);
    applyStimulus(OP_WITHDRAW, 16'd1, ST_INSUFF, 16'd0, "wd_insuff", 0);
    applyStimulus(OP_BALANCE, 16'd0, ST_OK, 16'd0, "bal_zero", 0);
    applyStimulus(OP_END_SESSION, 16'd0, ST_OK, 16'd0, "end_sess", 0);
    applyStimulus(OP_BALANCE, 16'd0, ST_NO_AUTH, 16'd0, "bal_after_end", 0);

    resetDut();
    applyStimulus(OP_WITHDRAW, 16'd100, ST_NO_AUTH, 16'd0, "wd_noauth", 0);
    applyStimulus(OP_PIN_CHECK, 16'h1234, ST_OK, 16'd10000, "pin_ok2", 0);
    applyStimulus(OP_WITHDRAW, 16'd0, ST_BAD_AMT, 16'd10000, "wd_zero", 0);
    applyStimulus(OP_BALANCE, 16'd0, ST_OK, 16'd10000, "bal_hold", 10);

    // Card pulled while a withdrawal is in processing.
    issueRaw(OP_WITHDRAW, 16'd500, "wd_abort", acc, ok);
    repeat (2) @(posedge clk);
    #1;
    cardRemoved = 1'b1;
    @(posedge clk);
    #1;
    cardRemoved = 1'b0;
    checkOutput("abort_req_ready", reqReady, 1);
    checkOutput("abort_rsp_valid", rspValid, 0);
    repeat (10) @(posedge clk);
    applyStimulus(OP_BALANCE, 16'd0, ST_NO_AUTH, 16'd0, "bal_after_abort", 0);
    applyStimulus(OP_PIN_CHECK, 16'h1234, ST_OK, 16'd10000, "pin_reauth", 0);
    applyStimulus(OP_BALANCE, 16'd0, ST_OK, 16'd10000, "bal_reauth", 0);

    // Card pulled on the same edge as a request in IDLE.
    @(negedge clk);
    reqOp       = OP_BALANCE;
    reqData     = 16'd0;
    reqValid    = 1'b1;
    cardRemoved = 1'b1;
    @(posedge clk);
    #1;
    reqValid    = 1'b0;
    cardRemoved = 1'b0;
    checkOutput("card_idle_req_ready", reqReady, 1);
    repeat (8) @(posedge clk);
    applyStimulus(OP_BALANCE, 16'd0, ST_NO_AUTH, 16'd0, "bal_after_card", 0);

    // Wrong-PIN counting, clearing on success, then lockout.
    applyStimulus(OP_PIN_CHECK, 16'h0000, ST_BAD_PIN, 16'd0, "bad1", 0);
    applyStimulus(OP_PIN_CHECK, 16'h0000, ST_BAD_PIN, 16'd0, "bad2", 0);
    applyStimulus(OP_PIN_CHECK, 16'h1234, ST_OK, 16'd10000, "pin_clear", 0);
    applyStimulus(OP_END_SESSION, 16'd0, ST_OK, 16'd0, "end_sess2", 0);
    applyStimulus(OP_PIN_CHECK, 16'h0000, ST_BAD_PIN, 16'd0, "bad3", 0);
    applyStimulus(OP_PIN_CHECK, 16'h0000, ST_BAD_PIN, 16'd0, "bad4", 0);
    applyStimulus(OP_PIN_CHECK, 16'h0000, ST_LOCKED, 16'd0, "bad_lock", 0);
    applyStimulus(OP_PIN_CHECK, 16'h1234, ST_LOCKED, 16'd0, "pin_locked", 0);
    applyStimulus(OP_WITHDRAW, 16'd5, ST_LOCKED, 16'd0, "wd_locked", 0);
    applyStimulus(OP_END_SESSION, 16'd0, ST_OK, 16'd0, "end_locked", 0);
    applyStimulus(OP_PIN_CHECK, 16'h1234, ST_LOCKED, 16'd0, "pin_still_locked", 0);

    // Reset in the middle of a transaction discards it.
    issueRaw(OP_WITHDRAW, 16'd100, "wd_reset", acc, ok);
    repeat (2) @(posedge clk);
    resetDut();
    repeat (10) @(posedge clk);
    applyStimulus(OP_PIN_CHECK, 16'h1234, ST_OK, 16'd10000, "pin_after_reset", 0);
    applyStimulus(OP_WITHDRAW, 16'd10000, ST_OK, 16'd0, "wd_exact", 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d failures %0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
